ws2812_frame_driver: RTL and testbench
======================================

# ws2812_frame_driver

Serializes LED colour words held in the dual-port WS2812 colour RAM onto a single WS2812 data line. It sits directly downstream of the RAM's second (read) port: the CPU writes colours through port 1, and this block reads port 2 and generates the NRZ bit stream followed by the latch/reset gap. Frames start on demand or, optionally, repeat automatically.

## Interface
Parameters:
- NUM_LEDS, 32: LEDs per frame (1..32); words 0..NUM_LEDS-1 are sent.
- BIT_CYCLES, 62: clk cycles per data bit (1.24 µs at 50 MHz).
- T0H_CYCLES, 20: high time of a '0' bit.
- T1H_CYCLES, 40: high time of a '1' bit.
- RESET_CYCLES, 3000: low latch gap after the last bit (60 µs at 50 MHz).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- auto_refresh  in  1  when high, a new frame starts automatically after each latch gap.
- busy  out  1  high from frame start until done.
- done  out  1  one-cycle pulse at the end of the latch gap.
- ram_address  out  5  word address to RAM port 2 (registered).
- ram_chipselect  out  1  high while busy; write2 is tied low externally.
- ram_clken  out  1  tied high while busy, low when idle.
- ram_readdata  in  32  RAM port 2 data, valid one cycle after ram_address changes.
- led_out  out  1  WS2812 data line.

## Operation
- Word format: bits [23:16] G, [15:8] R, [7:0] B. Bit 23 is sent first. Bits [31:24] are ignored.
- States:
  - IDLE: led_out=0, busy=0, ram_address=0.
  - FETCH: 1 cycle, waiting for RAM read latency.
  - LOAD: 1 cycle, captures ram_readdata[23:0] into the shift register and sets ram_address to 1.
  - SEND: 24 bits × BIT_CYCLES.
  - LATCH: RESET_CYCLES with led_out low.
  - DONE: 1 cycle, asserts done.
- Transitions:
  - IDLE→FETCH on start.
  - SEND→LATCH after bit 0 of LED NUM_LEDS-1.
  - LATCH→DONE when the latch counter expires.
  - DONE→FETCH if auto_refresh is high, otherwise DONE→IDLE.
- Bit encoding: in SEND, led_out is high for bit-counter values 0..TxH-1 and low for TxH..BIT_CYCLES-1. TxH is T1H_CYCLES if the current bit is 1, T0H_CYCLES if it is 0.
- Prefetch: during SEND of LED n, ram_address holds n+1. The next word is captured into a holding register on the last cycle of bit 12 and transferred to the shift register at the bit 0→next LED boundary. There is no gap between LEDs.
- The LED index counter is 5 bits. ram_address never exceeds NUM_LEDS-1. During the last LED it holds NUM_LEDS-1, and the prefetched data is discarded.
- start is ignored while busy, including a start in the DONE cycle.
- A start pulse coinciding with reset_n release is ignored.
- If auto_refresh drops mid-frame, the current frame completes and the block then goes to IDLE.
- RAM contents changed by the CPU mid-frame take effect for words not yet fetched.

## Timing
- All outputs are 0 during reset: led_out, busy, done, ram_address, ram_chipselect, ram_clken.
- Asserting reset_n low mid-frame forces led_out low asynchronously and returns to IDLE. No done pulse is generated.
- start at cycle 0 gives:
  - busy high at cycle 1;
  - FETCH at cycle 1, LOAD at cycle 2;
  - first led_out rising edge at cycle 3.
- Frame length, from the first led_out rise to the done pulse: NUM_LEDS×24×BIT_CYCLES + RESET_CYCLES cycles. done asserts on the last of these cycles.
- busy falls the cycle after done, unless auto_refresh restarts the frame. In that case busy stays high, and the next first rise occurs 3 cycles after done.
- Bit period is exactly BIT_CYCLES, with no jitter. High time is exactly T0H_CYCLES or T1H_CYCLES.

## Test plan
- NUM_LEDS=1, word 0=0x00FF0000, start pulse:
  - expect 8 bits with 40-cycle highs, then 16 bits with 20-cycle highs;
  - each bit is 62 cycles;
  - 3000 low cycles follow, then done;
  - done occurs 1488+3000 cycles after the first rise.
- NUM_LEDS=32, words = 0x00A5A5A5 + index:
  - decode led_out against RAM contents;
  - no idle gap appears between LEDs;
  - ram_address steps 0..31 and never exceeds 31.
- Extra start pulses at cycles 5 and 1000 of an active frame: no effect on led_out or frame length; exactly one done.
- auto_refresh=1 over 3 frames, then cleared during frame 3: three back-to-back frames separated only by the latch gap; busy stays high throughout, then falls after the third done.
- reset_n pulsed low mid-bit in LED 4:
  - led_out goes low in the same cycle (async);
  - all outputs return to 0;
  - the next start sends a full frame from word 0.
- CPU writes word 7=0x00000001 while LED 2 is being sent: LED 7 is transmitted as 0x000001.

Source files
------------

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver: reads colour words from RAM port 2 and serializes them
// as WS2812 NRZ bits (G,R,B, MSB first), followed by a low latch gap.
module ws2812_frame_driver #(
  parameter int NUM_LEDS     = 32,
  parameter int BIT_CYCLES   = 62,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int RESET_CYCLES = 3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        auto_refresh,
  output logic        busy,
  output logic        done,
  output logic [4:0]  ram_address,
  output logic        ram_chipselect,
  output logic        ram_clken,
  input  logic [31:0] ram_readdata,
  output logic        led_out
);
  localparam int BC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int LC_W = (RESET_CYCLES > 2) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [BC_W-1:0] BIT_LAST   = BC_W'(BIT_CYCLES - 1);
  localparam logic [BC_W-1:0] T0H        = BC_W'(T0H_CYCLES);
  localparam logic [BC_W-1:0] T1H        = BC_W'(T1H_CYCLES);
  // The DONE cycle is part of the low gap, so LATCH itself lasts one cycle less.
  localparam logic [LC_W-1:0] LATCH_LOAD = LC_W'(RESET_CYCLES - 2);
  localparam logic [4:0]      LAST_LED   = 5'(NUM_LEDS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, LATCH, DONE} state_t;

  state_t          state, state_nxt;
  logic            armed;
  logic [BC_W-1:0] bit_cnt;
  logic [4:0]      bit_num;
  logic [4:0]      led_idx;
  logic [LC_W-1:0] lat_cnt;
  logic [23:0]     shreg, hold;
  logic            bit_end, led_end, frame_end;
  logic [5:0]      addr_n2;
  logic [4:0]      addr_next;
  logic            unused_hi;

  assign unused_hi = ^ram_readdata[31:24];
  assign bit_end   = (bit_cnt == BIT_LAST);
  assign led_end   = bit_end && (bit_num == 5'd0);
  assign frame_end = led_end && (led_idx == LAST_LED);
  // Address for the LED after next, clamped so it never passes the last word.
  assign addr_n2   = {1'b0, led_idx} + 6'd2;
  assign addr_next = (addr_n2 > {1'b0, LAST_LED}) ? LAST_LED : addr_n2[4:0];

  assign ram_chipselect = busy;
  assign ram_clken      = busy;

  // Arms start one cycle after reset release so a coincident start is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b0;
    else          armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and decoded outputs; led_out is combinational so reset kills it at once.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    led_out   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && armed) state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD:  state_nxt = SEND;
      SEND: begin
        led_out = (bit_cnt < (shreg[23] ? T1H : T0H));
        if (frame_end) state_nxt = LATCH;
      end
      LATCH: if (lat_cnt == '0) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = auto_refresh ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing, shift/hold registers, prefetch address and latch counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      bit_num     <= '0;
      led_idx     <= '0;
      lat_cnt     <= '0;
      shreg       <= '0;
      hold        <= '0;
      ram_address <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg       <= ram_readdata[23:0];
          bit_cnt     <= '0;
          bit_num     <= 5'd23;
          led_idx     <= '0;
          ram_address <= (NUM_LEDS > 1) ? 5'd1 : 5'd0;
        end
        SEND: begin
          if (!bit_end) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            bit_cnt <= '0;
            // Mid-LED capture leaves plenty of margin after the address step.
            if (bit_num == 5'd12) hold <= ram_readdata[23:0];
            if (bit_num != 5'd0) begin
              bit_num <= bit_num - 1'b1;
              shreg   <= {shreg[22:0], 1'b0};
            end else begin
              bit_num <= 5'd23;
              shreg   <= hold;
              led_idx <= led_idx + 1'b1;
              if (led_idx == LAST_LED) begin
                ram_address <= '0;
                lat_cnt     <= LATCH_LOAD;
              end else begin
                ram_address <= addr_next;
              end
            end
          end
        end
        LATCH: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_frame_driver.sv
// tb_ws2812_frame_driver: scoreboard bench; a fast 32-LED instance for frame,
// restart, auto-refresh and reset scenarios, plus a default-timing 1-LED instance.
module tb_ws2812_frame_driver;
  localparam int N = 32, BC = 6, T0 = 2, T1 = 4, RC = 30;
  localparam int FRAME  = N * 24 * BC + RC;
  localparam int BC1    = 62;
  localparam int FRAME1 = 24 * 62 + 3000;

  logic        clk, reset_n;
  logic        start, auto_refresh, busy, done, cs, clken, led_out;
  logic [4:0]  ram_address;
  logic [31:0] ram_readdata;
  logic        start1, auto1, busy1, done1, cs1, clken1, led1;
  logic [4:0]  addr1;
  logic [31:0] rd1, word1;
  logic [31:0] mem [0:31];
  int checks, failures, cyc;

  ws2812_frame_driver #(.NUM_LEDS(N), .BIT_CYCLES(BC), .T0H_CYCLES(T0),
                        .T1H_CYCLES(T1), .RESET_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .auto_refresh(auto_refresh),
    .busy(busy), .done(done), .ram_address(ram_address), .ram_chipselect(cs),
    .ram_clken(clken), .ram_readdata(ram_readdata), .led_out(led_out));

  ws2812_frame_driver #(.NUM_LEDS(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .auto_refresh(auto1),
    .busy(busy1), .done(done1), .ram_address(addr1), .ram_chipselect(cs1),
    .ram_clken(clken1), .ram_readdata(rd1), .led_out(led1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter and registered-read RAM models.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    ram_readdata <= mem[ram_address];
    rd1          <= (addr1 == 5'd0) ? word1 : 32'hDEADBEEF;
  end

  typedef struct { int rise; int high; } pulse_t;
  pulse_t pq[$], pq1[$];
  int done_q[$], done_q1[$];
  int rise_t, rise_t1, addr_bad, addr_max, busy_fall;
  logic led_q, led1_q;
  logic [4:0] addr_q;
  logic [23:0] exp_q[$], got_q[$];

  // Pulse, done and address monitors sampled on the falling edge.
  always @(negedge clk) begin
    if (led_out && !led_q) rise_t = cyc;
    if (!led_out && led_q) pq.push_back('{rise_t, cyc - rise_t});
    if (led1 && !led1_q) rise_t1 = cyc;
    if (!led1 && led1_q) pq1.push_back('{rise_t1, cyc - rise_t1});
    if (done)  done_q.push_back(cyc);
    if (done1) done_q1.push_back(cyc);
    if (ram_address != addr_q && ram_address != 5'd0 && ram_address != addr_q + 5'd1)
      addr_bad++;
    if (int'(ram_address) > addr_max) addr_max = int'(ram_address);
    if (!busy && busy_fall < 0) busy_fall = cyc;
    led_q  = led_out;
    led1_q = led1;
    addr_q = ram_address;
  end

  task automatic pulse_start(output int sc);
    @(negedge clk); start = 1'b1; sc = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_start1(output int sc);
    @(negedge clk); start1 = 1'b1; sc = cyc;
    @(negedge clk); start1 = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic clear_all();
    pq.delete(); done_q.delete(); exp_q.delete(); got_q.delete();
  endtask

  task automatic load_frame();
    for (int i = 0; i < N; i++) mem[i] = 32'h5A000000 | (32'h00A5A5A5 + i);
  endtask

  task automatic push_exp();
    for (int i = 0; i < N; i++) exp_q.push_back(mem[i][23:0]);
  endtask

  // Decodes one frame of pulses into got_q; reports timing irregularities.
  task automatic collect_frame(output int first_rise, output int timing_bad, output bit ok);
    int g = 0, prev = -1;
    logic [23:0] w;
    pulse_t p;
    timing_bad = 0; first_rise = -1; ok = 1'b1;
    while (pq.size() < N * 24 && g < N * 24 * BC + 400) begin @(negedge clk); g++; end
    if (pq.size() < N * 24) begin
      ok = 1'b0; checks++; failures++;
      $display("FAIL collect_timeout pulses=%0d need=%0d", pq.size(), N * 24);
      return;
    end
    for (int l = 0; l < N; l++) begin
      w = '0;
      for (int b = 0; b < 24; b++) begin
        p = pq.pop_front();
        if (prev < 0) first_rise = p.rise;
        else if (p.rise - prev != BC) timing_bad++;
        if (p.high != T0 && p.high != T1) timing_bad++;
        prev = p.rise;
        w = {w[22:0], (p.high == T1)};
      end
      got_q.push_back(w);
    end
  endtask

  task automatic wait_done(output int td, output bit ok);
    int g = 0;
    while (done_q.size() == 0 && g < FRAME + 400) begin @(negedge clk); g++; end
    ok = (done_q.size() != 0);
    td = ok ? done_q.pop_front() : -1;
    if (!ok) begin checks++; failures++; $display("FAIL done_timeout got=none exp=done"); end
  endtask

  task automatic test_reset();
    int sc;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, ram_address, cs, clken, led_out} !== 10'd0) begin
      failures++; $display("FAIL reset_outputs got=%b exp=0", {busy, done, ram_address, cs, clken, led_out});
    end
    checks++;
    if ({busy1, done1, addr1, cs1, clken1, led1} !== 10'd0) begin
      failures++; $display("FAIL reset_outputs1 got=%b exp=0", {busy1, done1, addr1, cs1, clken1, led1});
    end
    // Start coincident with reset release must be dropped.
    @(negedge clk); reset_n = 1'b1; start = 1'b1; start1 = 1'b1; sc = cyc;
    @(negedge clk); start = 1'b0; start1 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, busy1, led_out, led1} !== 4'b0) begin
      failures++; $display("FAIL start_at_release got=%b exp=0000", {busy, busy1, led_out, led1});
    end
  endtask

  task automatic test_single_led();
    int sc, fr, prev, td, per_bad, g, e;
    int exp_h[$];
    pulse_t p;
    pq1.delete(); done_q1.delete();
    word1 = 32'h00FF0000;
    for (int i = 0; i < 24; i++) exp_h.push_back(i < 8 ? 40 : 20);
    pulse_start1(sc);
    checks++;
    if (busy1 !== 1'b1) begin failures++; $display("FAIL single_busy_c1 got=%b exp=1", busy1); end
    g = 0;
    while (pq1.size() < 24 && g < 24 * BC1 + 400) begin @(negedge clk); g++; end
    if (pq1.size() < 24) begin
      checks++; failures++; $display("FAIL single_timeout pulses=%0d need=24", pq1.size());
      return;
    end
    per_bad = 0; prev = -1; fr = -1;
    for (int b = 0; b < 24; b++) begin
      p = pq1.pop_front();
      e = exp_h.pop_front();
      checks++;
      if (p.high !== e) begin failures++; $display("FAIL single_bit%0d_high got=%0d exp=%0d", b, p.high, e); end
      if (prev < 0) fr = p.rise;
      else if (p.rise - prev != BC1) per_bad++;
      prev = p.rise;
    end
    checks++;
    if (per_bad != 0) begin failures++; $display("FAIL single_period bad=%0d exp=0", per_bad); end
    checks++;
    if (fr - sc != 3) begin failures++; $display("FAIL single_first_rise got=%0d exp=3", fr - sc); end
    g = 0;
    while (done_q1.size() == 0 && g < FRAME1 + 400) begin @(negedge clk); g++; end
    if (done_q1.size() == 0) begin
      checks++; failures++; $display("FAIL single_done_timeout got=none exp=done");
      return;
    end
    td = done_q1.pop_front();
    checks++;
    if (td - fr + 1 != FRAME1) begin failures++; $display("FAIL single_frame_len got=%0d exp=%0d", td - fr + 1, FRAME1); end
    checks++;
    if (pq1.size() != 0) begin failures++; $display("FAIL single_latch_low got=%0d exp=0 pulses", pq1.size()); end
    wait_cyc(td + 1);
    checks++;
    if (busy1 !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy1); end
  endtask

  task automatic test_frame32();
    int sc, fr, tb, td;
    bit ok;
    logic [23:0] e, w;
    clear_all(); load_frame(); push_exp();
    addr_bad = 0; addr_max = 0;
    pulse_start(sc);
    collect_frame(fr, tb, ok);
    if (!ok) return;
    checks++;
    if (fr - sc != 3) begin failures++; $display("FAIL f32_first_rise got=%0d exp=3", fr - sc); end
    checks++;
    if (tb != 0) begin failures++; $display("FAIL f32_bit_timing bad=%0d exp=0", tb); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front(); w = got_q.pop_front(); checks++;
      if (w !== e) begin failures++; $display("FAIL f32_word%0d got=%h exp=%h", i, w, e); end
    end
    wait_done(td, ok);
    if (!ok) return;
    checks++;
    if (td - fr + 1 != FRAME) begin failures++; $display("FAIL f32_frame_len got=%0d exp=%0d", td - fr + 1, FRAME); end
    wait_cyc(td + 1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL f32_busy_fall got=%b exp=0", busy); end
    checks++;
    if (addr_max != N - 1) begin failures++; $display("FAIL f32_addr_max got=%0d exp=%0d", addr_max, N - 1); end
    checks++;
    if (addr_bad != 0) begin failures++; $display("FAIL f32_addr_step bad=%0d exp=0", addr_bad); end
  endtask

  task automatic test_extra_start();
    int sc, fr, tb, td, g;
    bit ok;
    logic [23:0] e, w;
    clear_all(); push_exp();
    pulse_start(sc);
    wait_cyc(sc + 5);    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_cyc(sc + 1000); start = 1'b1; @(negedge clk); start = 1'b0;
    collect_frame(fr, tb, ok);
    if (!ok) return;
    checks++;
    if (tb != 0) begin failures++; $display("FAIL extra_bit_timing bad=%0d exp=0", tb); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front(); w = got_q.pop_front(); checks++;
      if (w !== e) begin failures++; $display("FAIL extra_word%0d got=%h exp=%h", i, w, e); end
    end
    // A start landing in the DONE cycle is ignored as well.
    g = 0;
    while (done !== 1'b1 && g < FRAME) begin @(negedge clk); g++; end
    td = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (td - fr + 1 != FRAME) begin failures++; $display("FAIL extra_frame_len got=%0d exp=%0d", td - fr + 1, FRAME); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL extra_done_start got=%b exp=0", busy); end
    repeat (20) @(negedge clk);
    checks++;
    if (done_q.size() != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL extra_one_done got=%0d exp=1 busy=%b", done_q.size(), busy);
    end
  endtask

  task automatic test_auto_refresh();
    int sc, fr, tb, td, td_prev, g;
    bit ok;
    logic [23:0] e, w;
    clear_all();
    for (int f = 0; f < 3; f++) push_exp();
    auto_refresh = 1'b1;
    pulse_start(sc);
    busy_fall = -1;
    td_prev = -1;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        g = 0;
        while (pq.size() < 10 && g < 1000) begin @(negedge clk); g++; end
        auto_refresh = 1'b0;
      end
      collect_frame(fr, tb, ok);
      if (!ok) return;
      checks++;
      if (tb != 0) begin failures++; $display("FAIL auto_f%0d_timing bad=%0d exp=0", f, tb); end
      if (td_prev >= 0) begin
        checks++;
        if (fr - td_prev != 3) begin failures++; $display("FAIL auto_f%0d_restart got=%0d exp=3", f, fr - td_prev); end
      end
      for (int i = 0; i < N; i++) begin
        e = exp_q.pop_front(); w = got_q.pop_front(); checks++;
        if (w !== e) begin failures++; $display("FAIL auto_f%0d_word%0d got=%h exp=%h", f, i, w, e); end
      end
      wait_done(td, ok);
      if (!ok) return;
      checks++;
      if (td - fr + 1 != FRAME) begin failures++; $display("FAIL auto_f%0d_len got=%0d exp=%0d", f, td - fr + 1, FRAME); end
      td_prev = td;
    end
    wait_cyc(td + 3);
    checks++;
    if (busy_fall != td + 1) begin failures++; $display("FAIL auto_busy_fall got=%0d exp=%0d", busy_fall, td + 1); end
    repeat (20) @(negedge clk);
    checks++;
    if (done_q.size() != 0 || pq.size() != 0) begin
      failures++; $display("FAIL auto_extra_frame got=%0d dones %0d pulses exp=0", done_q.size(), pq.size());
    end
  endtask

  task automatic test_reset_mid();
    int sc, fr, tb, td, g;
    bit ok;
    logic [23:0] e, w;
    clear_all();
    pulse_start(sc);
    g = 0;
    while ((pq.size() < 4 * 24 + 2 || led_out !== 1'b1) && g < 2000) begin @(negedge clk); g++; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 1'b0) begin failures++; $display("FAIL rst_async_led got=%b exp=0", led_out); end
    checks++;
    if ({busy, done, ram_address, cs, clken} !== 9'd0) begin
      failures++; $display("FAIL rst_mid_outputs got=%b exp=0", {busy, done, ram_address, cs, clken});
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done_q.size() != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_q.size()); end
    clear_all(); push_exp();
    pulse_start(sc);
    collect_frame(fr, tb, ok);
    if (!ok) return;
    checks++;
    if (fr - sc != 3 || tb != 0) begin failures++; $display("FAIL rst_restart rise=%0d timing=%0d exp=3/0", fr - sc, tb); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front(); w = got_q.pop_front(); checks++;
      if (w !== e) begin failures++; $display("FAIL rst_word%0d got=%h exp=%h", i, w, e); end
    end
    wait_done(td, ok);
  endtask

  task automatic test_cpu_write();
    int sc, fr, tb, td, g;
    bit ok;
    logic [23:0] e, w;
    clear_all(); load_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(i == 7 ? 24'h000001 : mem[i][23:0]);
    pulse_start(sc);
    g = 0;
    while (pq.size() < 2 * 24 + 1 && g < 2000) begin @(negedge clk); g++; end
    mem[7] = 32'h00000001;
    collect_frame(fr, tb, ok);
    if (!ok) return;
    checks++;
    if (tb != 0) begin failures++; $display("FAIL cpu_bit_timing bad=%0d exp=0", tb); end
    for (int i = 0; i < N; i++) begin
      e = exp_q.pop_front(); w = got_q.pop_front(); checks++;
      if (w !== e) begin failures++; $display("FAIL cpu_word%0d got=%h exp=%h", i, w, e); end
    end
    wait_done(td, ok);
    load_frame();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    reset_n = 1'b0; start = 1'b0; auto_refresh = 1'b0; start1 = 1'b0; auto1 = 1'b0;
    word1 = '0; ram_readdata = '0; rd1 = '0;
    led_q = 1'b0; led1_q = 1'b0; addr_q = '0;
    rise_t = 0; rise_t1 = 0; addr_bad = 0; addr_max = 0; busy_fall = -1;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_single_led();
    test_frame32();
    test_extra_start();
    test_auto_refresh();
    test_reset_mid();
    test_cpu_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
